hazard_ctrl: RTL

- Pipeline sequencer for the 5-stage core.
- Decides each cycle whether the PC and the IF/ID register advance, hold or flush, and whether a bubble goes into ID/EX.
- Owns the data-memory wait handshake, including a timeout watchdog.
- Sits beside the IF/ID and ID/EX registers and drives their stall/flush inputs and the PC write enable.

---
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/freeze sequencer with memory-wait watchdog (stats counters under HAZARD_STATS_EN)
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RegRt_i,
    input  logic [4:0]       IFID_RegRs_i,
    input  logic [4:0]       IFID_RegRt_i,
    input  logic             IFID_UsesRt_i,
    input  logic             Branch_taken_i,
    input  logic             Jump_i,
    input  logic             Mem_req_i,
    input  logic             Mem_ack_i,
    output logic             PCWrite_o,
    output logic             IFID_Stall_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Flush_o,
    output logic             Freeze_o,
    output logic             Error_o,
    output logic [CNT_W-1:0] Stall_cnt_o,
    output logic [CNT_W-1:0] Flush_cnt_o
);

    localparam int WC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_wait;
    logic              load_use;
    logic              timeout_hit;

    assign mem_wait = Mem_req_i & ~Mem_ack_i;
    assign load_use = IDEX_MemRead_i && (IDEX_RegRt_i != 5'd0) &&
                      ((IDEX_RegRt_i == IFID_RegRs_i) ||
                       (IFID_UsesRt_i && (IDEX_RegRt_i == IFID_RegRt_i)));

    // wait_cnt holds the wait cycles already completed, so the current cycle is the
    // MEM_TIMEOUT-th when it equals MEM_TIMEOUT-1.
    assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    wait_cnt_d = WC_W'(1);
                    state_d    = (MEM_TIMEOUT == 1) ? ST_ERROR : ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_wait) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // While rst_i is high the trap state is masked so decode behaves as RUN.
    always_comb begin
        PCWrite_o    = 1'b1;
        IFID_Stall_o = 1'b0;
        IFID_Flush_o = 1'b0;
        IDEX_Flush_o = 1'b0;
        Freeze_o     = 1'b0;
        if (((state_q == ST_ERROR) && !rst_i) || mem_wait) begin
            Freeze_o     = 1'b1;
            PCWrite_o    = 1'b0;
            IFID_Stall_o = 1'b1;
        end else if (load_use) begin
            PCWrite_o    = 1'b0;
            IFID_Stall_o = 1'b1;
            IDEX_Flush_o = 1'b1;
        end else if (Branch_taken_i || Jump_i) begin
            IFID_Flush_o = 1'b1;
        end
    end

    assign Error_o = (state_q == ST_ERROR);

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!PCWrite_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (IFID_Flush_o && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign Stall_cnt_o = stall_cnt_q;
    assign Flush_cnt_o = flush_cnt_q;
`else
    assign Stall_cnt_o = '0;
    assign Flush_cnt_o = '0;
`endif

endmodule
